// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage.
// Operation entry layout, select codes, FSM states.
package alu_pkg;

   localparam int OP_W = 19;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOT = 3'b101,
      ALU_SHL = 3'b110,
      ALU_SHR = 3'b111
   } alu_sel_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      alu_sel_t   sel;
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Operation request and result handshake bundle.
// master = producer/consumer side, slave = issue stage.
interface alu_issue_ctrl_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_sel;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       res_zero;

   modport master (
      output in_valid, in_a, in_b, in_sel, res_ready,
      input  in_ready, res_valid, res_data, res_carry, res_zero
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sel, res_ready,
      output in_ready, res_valid, res_data, res_carry, res_zero
   );

endinterface

// File: rtl/op_fifo.sv
// Synchronous FIFO with combinational head read.
// Push/pop are ignored when full/empty respectively.
module op_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 19,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand FIFO in front of the external ALU and a
// single-entry result slot behind it.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int W     = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_issue_ctrl_if.slave io,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   output logic [2:0]    alu_sel,
   input  logic [W-1:0]  alu_out,
   input  logic          alu_carry,
   output logic [CW-1:0] fifo_count,
   output logic [15:0]   ops_done,
   output state_t        state
);

   op_t           wr_op;
   op_t           hd_op;
   logic          full;
   logic          empty;
   logic          push;
   logic          cap;
   logic          nxt_rv;
   logic [CW-1:0] nxt_cnt;

   assign wr_op = '{a: io.in_a, b: io.in_b,
                    sel: alu_sel_t'(io.in_sel)};

   assign io.in_ready = !rst && !full;
   assign push        = io.in_valid && io.in_ready;
   assign cap         = !empty && (!io.res_valid || io.res_ready);

   op_fifo #(
      .DEPTH (DEPTH),
      .W     (OP_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (cap),
      .wdata (wr_op),
      .head  (hd_op),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Idle ALU sees zeros so it never toggles on stale entries.
   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = '0;
      if (!empty) begin
         alu_a   = hd_op.a;
         alu_b   = hd_op.b;
         alu_sel = hd_op.sel;
      end
   end

   assign nxt_cnt = fifo_count + CW'(push) - CW'(cap);
   assign nxt_rv  = cap || (io.res_valid && !io.res_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         io.res_valid <= 1'b0;
         io.res_data  <= '0;
         io.res_carry <= 1'b0;
         io.res_zero  <= 1'b0;
         ops_done     <= '0;
         state        <= IDLE;
      end else begin
         if (cap) begin
            io.res_data  <= alu_out;
            io.res_carry <= alu_carry;
            io.res_zero  <= (alu_out == '0);
            ops_done     <= ops_done + 1'b1;
         end
         io.res_valid <= nxt_rv;
         unique case (1'b1)
            (nxt_cnt == '0 && !nxt_rv):
               state <= IDLE;
            (nxt_cnt != '0 && nxt_rv && !io.res_ready):
               state <= STALL;
            default:
               state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural
// ALU standing in for the parent-level instance.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [2:0]    alu_sel;
   logic [7:0]    alu_out;
   logic          alu_carry;
   logic [CW-1:0] fifo_count;
   logic [15:0]   ops_done;
   state_t        st;

   int checks = 0;
   int errors = 0;

   alu_issue_ctrl_if io ();

   alu_issue_ctrl #(.DEPTH(DEPTH), .W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .io         (io.slave),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_carry  (alu_carry),
      .fifo_count (fifo_count),
      .ops_done   (ops_done),
      .state      (st)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_carry = 1'b0;
      alu_out   = '0;
      case (alu_sel)
         3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001: alu_out = alu_a - alu_b;
         3'b010: alu_out = alu_a & alu_b;
         3'b011: alu_out = alu_a | alu_b;
         3'b100: alu_out = alu_a ^ alu_b;
         3'b101: alu_out = ~alu_a;
         3'b110: alu_out = alu_a << 1;
         default: alu_out = alu_a >> 1;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [2:0] s);
      io.in_valid = 1'b1;
      io.in_a     = a;
      io.in_b     = b;
      io.in_sel   = s;
   endtask

   // Back-pressure drain order (op0 captured first)
   logic [7:0] bp_exp [5] = '{8'h02, 8'h0D, 8'h30, 8'h3F, 8'hA5};

   // Streaming ops and expected results
   logic [7:0] s_a [8] = '{8'h81, 8'hAA, 8'h80, 8'h81,
                           8'hFF, 8'h0F, 8'h12, 8'h20};
   logic [7:0] s_b [8] = '{8'h00, 8'hFF, 8'h80, 8'h00,
                           8'h00, 8'hF0, 8'h21, 8'h01};
   logic [2:0] s_s [8] = '{3'b110, 3'b100, 3'b000, 3'b111,
                           3'b101, 3'b010, 3'b011, 3'b001};
   logic [7:0] s_d [8] = '{8'h02, 8'h55, 8'h00, 8'h40,
                           8'h00, 8'h00, 8'h33, 8'h1F};
   logic       s_c [8] = '{1'b0, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0};
   logic       s_z [8] = '{1'b0, 1'b0, 1'b1, 1'b0,
                           1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      rst          = 1'b1;
      io.in_valid  = 1'b0;
      io.in_a      = '0;
      io.in_b      = '0;
      io.in_sel    = '0;
      io.res_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(io.in_ready), 0);
      chk("rst_rv", 32'(io.res_valid), 0);
      chk("rst_cnt", 32'(fifo_count), 0);
      chk("rst_ops", 32'(ops_done), 0);
      chk("rst_state", 32'(st), 32'(IDLE));
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(io.in_ready), 1);
      chk("idle_alu_a", 32'(alu_a), 0);

      // add with carry
      io.res_ready = 1'b1;
      offer(8'hF0, 8'h20, 3'b000);
      #1;
      chk("no_bypass", 32'(alu_a), 0);
      tick();
      io.in_valid = 1'b0;
      chk("add_cnt", 32'(fifo_count), 1);
      chk("add_rv0", 32'(io.res_valid), 0);
      chk("add_state", 32'(st), 32'(RUN));
      chk("add_alu_a", 32'(alu_a), 32'h F0);
      tick();
      chk("add_rv", 32'(io.res_valid), 1);
      chk("add_data", 32'(io.res_data), 32'h10);
      chk("add_carry", 32'(io.res_carry), 1);
      chk("add_zero", 32'(io.res_zero), 0);
      chk("add_ops", 32'(ops_done), 1);
      chk("add_cnt0", 32'(fifo_count), 0);
      tick();
      chk("drain_rv", 32'(io.res_valid), 0);
      chk("drain_hold", 32'(io.res_data), 32'h10);
      chk("drain_idle", 32'(st), 32'(IDLE));

      // zero flag
      offer(8'h05, 8'h05, 3'b001);
      tick();
      io.in_valid = 1'b0;
      tick();
      chk("sub_data", 32'(io.res_data), 0);
      chk("sub_zero", 32'(io.res_zero), 1);
      chk("sub_carry", 32'(io.res_carry), 0);
      chk("sub_ops", 32'(ops_done), 2);
      tick();

      // back-pressure
      io.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: offer(8'h01, 8'h01, 3'b000);
            1: offer(8'h10, 8'h03, 3'b001);
            2: offer(8'hF0, 8'h3C, 3'b010);
            3: offer(8'h0F, 8'h30, 3'b011);
            default: offer(8'h5A, 8'h00, 3'b101);
         endcase
         #1;
         chk($sformatf("bp_ready%0d", i), 32'(io.in_ready), 1);
         tick();
      end
      chk("bp_cnt", 32'(fifo_count), 4);
      chk("bp_in_ready", 32'(io.in_ready), 0);
      chk("bp_rv", 32'(io.res_valid), 1);
      chk("bp_data0", 32'(io.res_data), 32'h02);
      chk("bp_state", 32'(st), 32'(STALL));
      offer(8'h77, 8'h77, 3'b000);
      tick();
      io.in_valid = 1'b0;
      chk("bp_reject_cnt", 32'(fifo_count), 4);
      chk("bp_ops", 32'(ops_done), 3);
      chk("bp_hold", 32'(io.res_data), 32'h02);
      io.res_ready = 1'b1;
      #1;
      chk("bp_full_pop_ready", 32'(io.in_ready), 0);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk($sformatf("bp_drain%0d", i), 32'(io.res_data), 32'(bp_exp[i]));
         chk($sformatf("bp_drv%0d", i), 32'(io.res_valid), 1);
      end
      chk("bp_ops_end", 32'(ops_done), 7);
      tick();
      chk("bp_empty_rv", 32'(io.res_valid), 0);
      chk("bp_empty_cnt", 32'(fifo_count), 0);

      // streaming
      for (int k = 0; k < 8; k++) begin
         offer(s_a[k], s_b[k], s_s[k]);
         tick();
         chk($sformatf("st_cnt%0d", k), 32'(fifo_count <= 1), 1);
         if (k >= 1) begin
            chk($sformatf("st_rv%0d", k - 1), 32'(io.res_valid), 1);
            chk($sformatf("st_d%0d", k - 1), 32'(io.res_data), 32'(s_d[k - 1]));
            chk($sformatf("st_c%0d", k - 1), 32'(io.res_carry), 32'(s_c[k - 1]));
            chk($sformatf("st_z%0d", k - 1), 32'(io.res_zero), 32'(s_z[k - 1]));
         end
      end
      io.in_valid = 1'b0;
      tick();
      chk("st_rv7", 32'(io.res_valid), 1);
      chk("st_d7", 32'(io.res_data), 32'(s_d[7]));
      chk("st_ops", 32'(ops_done), 15);
      tick();
      chk("st_end_rv", 32'(io.res_valid), 0);

      // reset mid-operation
      io.res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(8'h11, 8'h22, 3'b000);
         tick();
      end
      io.in_valid = 1'b0;
      chk("mr_cnt3", 32'(fifo_count), 3);
      chk("mr_rv1", 32'(io.res_valid), 1);
      rst = 1'b1;
      tick();
      chk("mr_cnt", 32'(fifo_count), 0);
      chk("mr_rv", 32'(io.res_valid), 0);
      chk("mr_data", 32'(io.res_data), 0);
      chk("mr_carry", 32'(io.res_carry), 0);
      chk("mr_zero", 32'(io.res_zero), 0);
      chk("mr_ops", 32'(ops_done), 0);
      chk("mr_state", 32'(st), 32'(IDLE));
      chk("mr_in_ready", 32'(io.in_ready), 0);
      chk("mr_alu_a", 32'(alu_a), 0);
      rst = 1'b0;
      io.res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mr_stale%0d", i), 32'(io.res_valid), 0);
      end

      // ops_done wrap
      force dut.ops_done = 16'hFFFF;
      #1;
      release dut.ops_done;
      #1;
      chk("wrap_pre", 32'(ops_done), 32'hFFFF);
      offer(8'h03, 8'h04, 3'b000);
      tick();
      io.in_valid = 1'b0;
      tick();
      chk("wrap_rv", 32'(io.res_valid), 1);
      chk("wrap_data", 32'(io.res_data), 32'h07);
      chk("wrap_ops", 32'(ops_done), 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
